mpq_cmd_sched: RTL and testbench
================================

MPQ_CMD_SCHED -- requirements
Module: mpq_cmd_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requester ports, range 2..8.
REQ-002 SHALL have parameter IDW, default 3: requester-ID width carried on gnt_id.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester command pending, held until granted.
REQ-006 SHALL have port req_cmd, input, 3*NREQ: per-requester opcode; 0 build, 1 extract, 2 decrease, 3 insert, 4-7 write-out.
REQ-007 SHALL have ports req_index and req_value, input, 8*NREQ each: per-requester operands.
REQ-008 SHALL have port req_gnt, output, NREQ: one-hot, one-cycle pulse; the command is consumed.
REQ-009 SHALL have port gnt_id, output, IDW: index of the last granted requester.
REQ-010 SHALL have ports cmd_valid (1), cmd (3), index (8), value (8), all outputs: command to the priority-queue engine.
REQ-011 SHALL have port busy, input, 1: engine busy; low only while the engine waits for a command.
REQ-012 SHALL have port data_valid, input, 1: tap of the engine's load stream.
REQ-013 SHALL have port done, input, 1: engine write-out complete.
REQ-014 SHALL have port sched_done, output, 1: level, set after the write-out completes.
REQ-015 SHALL have port err, output, 1: one-cycle pulse when a command is dropped.

Function
REQ-016 SHALL implement the states INIT, IDLE, ISSUE, WAIT_HI, WAIT_LO, FLUSH and FIN.
REQ-017 INIT SHALL persist until busy has been seen high and then low (load finished), then SHALL move to IDLE; no grant SHALL be issued in INIT.
REQ-018 IDLE with busy=0 and any req_valid SHALL grant round-robin, starting the search one above the last grant (wrap NREQ-1 to 0); after reset the search SHALL start at requester 0.
REQ-019 On a grant, the scheduler SHALL in the same cycle pulse req_gnt, register the granted cmd/index/value, and go to ISSUE.
REQ-020 ISSUE SHALL drive cmd_valid=1 for exactly one cycle with the registered operands, then go to WAIT_HI.
REQ-021 WAIT_HI SHALL wait for busy=1, then go to WAIT_LO; WAIT_LO SHALL wait for busy=0, then go to IDLE.
REQ-022 Grant-to-next-grant latency SHALL be at least 4 cycles; cmd_valid SHALL never be asserted while busy=1 or in two consecutive cycles.
REQ-023 A granted write-out (cmd>=4) SHALL go ISSUE -> FLUSH; FLUSH SHALL wait for done=1, then go to FIN.
REQ-024 FIN SHALL set sched_done=1 and grant nothing until rst.
REQ-025 A simultaneous req_valid and busy=1 SHALL yield no grant; the requester SHALL hold its request.
REQ-026 cmd, index and value SHALL hold their last values when cmd_valid=0.

Reset
REQ-027 rst SHALL force INIT, round-robin pointer = NREQ-1, cmd_valid=0, cmd/index/value=0, req_gnt=0, gnt_id=0, sched_done=0, err=0.
REQ-028 rst asserted mid-command SHALL abandon it immediately without issuing cmd_valid afterwards.

Configuration
REQ-029 With MPQ_SCHED_GUARD_EN defined, an 8-bit element count SHALL be kept: it SHALL increment on data_valid in INIT, increment on an issued insert, and decrement on an issued extract.
REQ-030 With MPQ_SCHED_GUARD_EN defined, an extract at count 0, an insert at count 255, or a decrease with index 0 or index > count SHALL still be granted, but cmd_valid SHALL not be asserted, err SHALL pulse, and the state SHALL return to IDLE.
REQ-031 Without MPQ_SCHED_GUARD_EN, every granted command SHALL be forwarded and err SHALL be tied 0.

Structure
REQ-032 A shared package SHALL hold the opcode constants (CMD_BUILD=0, CMD_EXTRACT=1, CMD_DECREASE=2, CMD_INSERT=3, CMD_WRITE=4) and the state encodings.
REQ-033 The round-robin pick SHALL be a sub-module, mpq_rr_arb (inputs: request vector and last grant; output: one-hot grant).

Verification
REQ-034 Bench SHALL apply reset, hold busy low 3 cycles, then drive busy high with 5 data_valid beats, then busy low -> no req_gnt before busy falls; with the guard enabled, count=5.
REQ-035 Bench SHALL assert req_valid=4'b1111 continuously -> grants in order 0,1,2,3,0, each followed by exactly one cmd_valid after the engine busy round-trip.
REQ-036 Bench SHALL have requester 2 send insert value 8'h07 -> cmd=3, value=8'h07, cmd_valid for one cycle, gnt_id=2.
REQ-037 With the guard enabled and count=0, bench SHALL issue an extract -> req_gnt pulses, cmd_valid stays 0, err pulses once.
REQ-038 Bench SHALL issue a write cmd 4 and raise done 10 cycles later -> sched_done=1, and later req_valid receives no grant.
REQ-039 Bench SHALL assert rst during WAIT_LO -> all outputs at reset values next cycle, and INIT is re-entered.

Source files
------------

// File: rtl/mpq_cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// mpq_cmd_sched_pkg
// Shared definitions for the priority-queue command scheduler:
//   - engine opcodes (CMD_*)
//   - scheduler FSM state encoding (state_t)
//   - small helpers for opcode decode and the optional command guard
// Optional feature macro used by the importing RTL: MPQ_SCHED_GUARD_EN
// -----------------------------------------------------------------------------
package mpq_cmd_sched_pkg;

    localparam logic [2:0] CMD_BUILD    = 3'd0;
    localparam logic [2:0] CMD_EXTRACT  = 3'd1;
    localparam logic [2:0] CMD_DECREASE = 3'd2;
    localparam logic [2:0] CMD_INSERT   = 3'd3;
    localparam logic [2:0] CMD_WRITE    = 3'd4;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        ISSUE   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        FLUSH   = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Opcodes 4..7 all mean write-out, so only the top bit matters.
    function automatic logic cmd_is_write(input logic [2:0] c);
        return c[2];
    endfunction

    // True when the command would corrupt the engine given the current
    // element count: extracting from an empty queue, inserting into a full
    // one, or decreasing a key at an index outside 1..count.
    function automatic logic cmd_rejected(input logic [2:0] c,
                                          input logic [7:0] idx,
                                          input logic [7:0] count);
        logic r;
        r = 1'b0;
        if (c == CMD_EXTRACT && count == 8'd0)
            r = 1'b1;
        if (c == CMD_INSERT && count == 8'd255)
            r = 1'b1;
        if (c == CMD_DECREASE && (idx == 8'd0 || idx > count))
            r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mpq_rr_arb.sv
// -----------------------------------------------------------------------------
// mpq_rr_arb
// Round-robin pick: grants the first active request strictly above the last
// granted index, wrapping to the lowest active request.
// Ports:
//   req  [NREQ-1:0]  request vector
//   last [IDW-1:0]   index of the previous grant
//   gnt  [NREQ-1:0]  one-hot grant (all zero when req is zero)
// -----------------------------------------------------------------------------
module mpq_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0] above;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pick_src;

    // Positions strictly above the last grant get first chance.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_above
            assign above[gi] = (gi > int'(last));
        end
    endgenerate

    assign masked   = req & above;
    assign pick_src = (|masked) ? masked : req;
    // Isolate the lowest set bit.
    assign gnt      = pick_src & (~pick_src + NREQ'(1));

endmodule

// File: rtl/mpq_cmd_sched.sv
// -----------------------------------------------------------------------------
// mpq_cmd_sched
// Arbitrates commands from NREQ requesters onto a single priority-queue
// engine. Waits for the initial load, then grants round-robin, issues one
// command per engine busy round-trip, and stops after a write-out.
// Optional feature macro: MPQ_SCHED_GUARD_EN -- tracks the element count and
// drops (with an err pulse) commands that would underflow/overflow the queue.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid [NREQ]         pending command per requester
//   req_cmd   [3*NREQ]       per-requester opcode
//   req_index/req_value [8*NREQ] per-requester operands
//   req_gnt   [NREQ]         one-hot grant pulse (command consumed)
//   gnt_id    [IDW]          index of the last granted requester
//   cmd_valid, cmd, index, value  command to the engine
//   busy, data_valid, done   engine status inputs
//   sched_done               level, set once the write-out completes
//   err                      pulse when a granted command is dropped
// -----------------------------------------------------------------------------
module mpq_cmd_sched
    import mpq_cmd_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [3*NREQ-1:0]   req_cmd,
    input  logic [8*NREQ-1:0]   req_index,
    input  logic [8*NREQ-1:0]   req_value,
    output logic [NREQ-1:0]     req_gnt,
    output logic [IDW-1:0]      gnt_id,
    output logic                cmd_valid,
    output logic [2:0]          cmd,
    output logic [7:0]          index,
    output logic [7:0]          value,
    input  logic                busy,
    input  logic                data_valid,
    input  logic                done,
    output logic                sched_done,
    output logic                err
);

    state_t          state_reg, state_next;
    logic            seen_hi_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  gnt_id_reg;
    logic [2:0]      cmd_reg;
    logic [7:0]      index_reg;
    logic [7:0]      value_reg;

    logic [NREQ-1:0] arb_gnt;
    logic            grant_en;
    logic [IDW-1:0]  gnt_idx;
    logic [2:0]      sel_cmd;
    logic [7:0]      sel_index;
    logic [7:0]      sel_value;
    logic            drop;

    mpq_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req  (req_valid),
        .last (ptr_reg),
        .gnt  (arb_gnt)
    );

    // Grants only happen while the engine is idle waiting for a command.
    assign grant_en = (state_reg == IDLE) && !busy && (|req_valid);
    assign req_gnt  = grant_en ? arb_gnt : '0;

    // Encode the one-hot pick and select that requester's operands.
    always_comb begin
        gnt_idx   = '0;
        sel_cmd   = '0;
        sel_index = '0;
        sel_value = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx   = IDW'(i);
                sel_cmd   = req_cmd[i*3 +: 3];
                sel_index = req_index[i*8 +: 8];
                sel_value = req_value[i*8 +: 8];
            end
        end
    end

`ifdef MPQ_SCHED_GUARD_EN
    logic [7:0] count_reg;
    logic       drop_reg;

    // The drop decision is taken at grant time; the count cannot change
    // between grant and issue, so the check stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 8'd0;
            drop_reg  <= 1'b0;
        end else begin
            if (grant_en)
                drop_reg <= cmd_rejected(sel_cmd, sel_index, count_reg);
            if (state_reg == INIT && data_valid && count_reg != 8'd255)
                count_reg <= count_reg + 8'd1;
            else if (state_reg == ISSUE && !drop_reg) begin
                if (cmd_reg == CMD_INSERT)
                    count_reg <= count_reg + 8'd1;
                else if (cmd_reg == CMD_EXTRACT)
                    count_reg <= count_reg - 8'd1;
            end
        end
    end

    assign drop = drop_reg;
`else
    // The load tap only feeds the element count, which this build omits.
    logic unused_data_valid;
    assign unused_data_valid = data_valid;
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= INIT;
            seen_hi_reg <= 1'b0;
            ptr_reg     <= IDW'(NREQ - 1);
            gnt_id_reg  <= '0;
            cmd_reg     <= '0;
            index_reg   <= '0;
            value_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // INIT is left only after the initial load has raised busy once.
            if (state_reg == INIT && busy)
                seen_hi_reg <= 1'b1;
            if (grant_en) begin
                ptr_reg    <= gnt_idx;
                gnt_id_reg <= gnt_idx;
                cmd_reg    <= sel_cmd;
                index_reg  <= sel_index;
                value_reg  <= sel_value;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_valid  = 1'b0;
        err        = 1'b0;
        sched_done = 1'b0;
        case (state_reg)
            INIT: begin
                if (seen_hi_reg && !busy)
                    state_next = IDLE;
            end
            IDLE: begin
                if (grant_en)
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (drop) begin
                    err        = 1'b1;
                    state_next = IDLE;
                end else begin
                    cmd_valid  = 1'b1;
                    state_next = cmd_is_write(cmd_reg) ? FLUSH : WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (busy)
                    state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!busy)
                    state_next = IDLE;
            end
            FLUSH: begin
                if (done)
                    state_next = FIN;
            end
            FIN: begin
                sched_done = 1'b1;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign gnt_id = gnt_id_reg;
    assign cmd    = cmd_reg;
    assign index  = index_reg;
    assign value  = value_reg;

endmodule

// File: tb/tb_mpq_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_mpq_cmd_sched
// Directed bench for mpq_cmd_sched (NREQ=4, IDW=3). Inputs change on the
// falling edge; outputs are sampled 1 ns later. Guard-specific steps follow
// MPQ_SCHED_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_mpq_cmd_sched;
    import mpq_cmd_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_cmd;
    logic [31:0] req_index;
    logic [31:0] req_value;
    logic [3:0]  req_gnt;
    logic [2:0]  gnt_id;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [7:0]  index;
    logic [7:0]  value;
    logic        busy;
    logic        data_valid;
    logic        done;
    logic        sched_done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mpq_cmd_sched #(
        .NREQ (4),
        .IDW  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_index  (req_index),
        .req_value  (req_value),
        .req_gnt    (req_gnt),
        .gnt_id     (gnt_id),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .index      (index),
        .value      (value),
        .busy       (busy),
        .data_valid (data_valid),
        .done       (done),
        .sched_done (sched_done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string where);
        chk({where, "_cmd_valid"},  32'(cmd_valid),  32'd0);
        chk({where, "_cmd"},        32'(cmd),        32'd0);
        chk({where, "_index"},      32'(index),      32'd0);
        chk({where, "_value"},      32'(value),      32'd0);
        chk({where, "_req_gnt"},    32'(req_gnt),    32'd0);
        chk({where, "_gnt_id"},     32'(gnt_id),     32'd0);
        chk({where, "_sched_done"}, 32'(sched_done), 32'd0);
        chk({where, "_err"},        32'(err),        32'd0);
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic [7:0] ix, input logic [7:0] v);
        req_cmd[i*3 +: 3]   = c;
        req_index[i*8 +: 8] = ix;
        req_value[i*8 +: 8] = v;
    endtask

    // One full command: grant in IDLE, issue, engine busy round-trip.
    // Entered just before the falling edge on which the DUT sits in IDLE.
    task automatic serve(input int id, input logic [2:0] c, input logic [7:0] ix, input logic [7:0] v);
        @(negedge clk); busy = 1'b0; #1;
        chk("gnt", 32'(req_gnt), 32'(1 << id));
        chk("gnt_err", 32'(err), 32'd0);
        @(negedge clk); #1;
        chk("issue_valid", 32'(cmd_valid), 32'd1);
        chk("issue_cmd",   32'(cmd),       32'(c));
        chk("issue_index", 32'(index),     32'(ix));
        chk("issue_value", 32'(value),     32'(v));
        chk("issue_id",    32'(gnt_id),    32'(id));
        chk("issue_nognt", 32'(req_gnt),   32'd0);
        $display("txn: grant id=%0d cmd=%0d index=%02h value=%02h", gnt_id, cmd, index, value);
        @(negedge clk); busy = 1'b1; #1;
        chk("wait_hi_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk); #1;
        chk("wait_lo_nognt", 32'(req_gnt), 32'd0);
        chk("wait_lo_hold",  32'(cmd),     32'(c));
        @(negedge clk); busy = 1'b0; #1;
        chk("wait_lo_end_nognt", 32'(req_gnt),   32'd0);
        chk("wait_lo_end_valid", 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        busy       = 1'b0;
        data_valid = 1'b0;
        done       = 1'b0;
        req_valid  = 4'b0000;
        req_cmd    = '0;
        req_index  = '0;
        req_value  = '0;

        // Reset state.
        @(negedge clk); @(negedge clk); #1;
        chk_reset("reset");

        // Initial load: busy low 3 cycles, high with 5 data beats, then low.
        @(negedge clk); rst = 1'b0; req_valid = 4'b1111;
        set_req(0, CMD_BUILD,    8'h10, 8'h20);
        set_req(1, CMD_INSERT,   8'h11, 8'h21);
        set_req(2, CMD_INSERT,   8'h12, 8'h07);
        set_req(3, CMD_DECREASE, 8'h03, 8'h23);
        #1; chk("init_lo0", 32'(req_gnt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("init_lo", 32'(req_gnt), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); busy = 1'b1; data_valid = 1'b1; #1;
            chk("init_hi", 32'(req_gnt), 32'd0);
        end
        @(negedge clk); busy = 1'b0; data_valid = 1'b0; #1;
        chk("init_fall", 32'(req_gnt), 32'd0);
`ifdef MPQ_SCHED_GUARD_EN
        chk("init_count", 32'(dut.count_reg), 32'd5);
`endif

        // Round-robin with all requesters active.
        serve(0, CMD_BUILD,    8'h10, 8'h20);
        serve(1, CMD_INSERT,   8'h11, 8'h21);
        serve(2, CMD_INSERT,   8'h12, 8'h07);
        serve(3, CMD_DECREASE, 8'h03, 8'h23);
        serve(0, CMD_BUILD,    8'h10, 8'h20);
`ifdef MPQ_SCHED_GUARD_EN
        chk("rr_count", 32'(dut.count_reg), 32'd7);
`endif

        // Request while the engine is busy: held, no grant.
        @(negedge clk); busy = 1'b1; req_valid = 4'b0010;
        set_req(1, CMD_WRITE, 8'h31, 8'h41);
        #1; chk("busy_nognt", 32'(req_gnt), 32'd0);

        // Write-out from requester 1, done 10 cycles after the issue.
        @(negedge clk); busy = 1'b0; #1;
        chk("wr_gnt", 32'(req_gnt), 32'b0010);
        @(negedge clk); req_valid = 4'b0000; #1;
        chk("wr_valid", 32'(cmd_valid), 32'd1);
        chk("wr_cmd",   32'(cmd),       32'd4);
        chk("wr_index", 32'(index),     32'h31);
        chk("wr_id",    32'(gnt_id),    32'd1);
        $display("txn: grant id=%0d cmd=%0d index=%02h value=%02h", gnt_id, cmd, index, value);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); #1;
            chk("flush_notdone", 32'(sched_done), 32'd0);
        end
        @(negedge clk); done = 1'b1; #1;
        chk("flush_done_cycle", 32'(sched_done), 32'd0);
        @(negedge clk); done = 1'b0; req_valid = 4'b1111; #1;
        chk("fin_done", 32'(sched_done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("fin_nognt",  32'(req_gnt),    32'd0);
            chk("fin_level",  32'(sched_done), 32'd1);
            chk("fin_nocmd",  32'(cmd_valid),  32'd0);
        end

        // Reset out of FIN.
        @(negedge clk); rst = 1'b1; #1;
        chk_reset("rst_fin");
        @(negedge clk); rst = 1'b0; busy = 1'b1; #1;
        chk("reinit_hi", 32'(req_gnt), 32'd0);
        @(negedge clk); busy = 1'b0; #1;
        chk("reinit_lo", 32'(req_gnt), 32'd0);
        // After reset the search starts at requester 0.
        @(negedge clk); #1;
        chk("post_rst_gnt", 32'(req_gnt), 32'b0001);
        @(negedge clk); #1;
        chk("post_rst_valid", 32'(cmd_valid), 32'd1);
        chk("post_rst_cmd",   32'(value),     32'h20);
        @(negedge clk); busy = 1'b1; #1;
        // Now in WAIT_LO: abandon the command with an asynchronous reset.
        @(negedge clk); rst = 1'b1; #1;
        chk_reset("rst_wait_lo");
        @(negedge clk); rst = 1'b0; busy = 1'b0; #1;
        chk("after_rst_valid", 32'(cmd_valid), 32'd0);
        chk("after_rst_gnt",   32'(req_gnt),   32'd0);
        @(negedge clk); #1;
        chk("reinit_no_gnt",   32'(req_gnt),   32'd0);
        chk("reinit_no_valid", 32'(cmd_valid), 32'd0);

        // Extract with no data loaded (count 0).
        @(negedge clk); busy = 1'b1; req_valid = 4'b0001;
        set_req(0, CMD_EXTRACT, 8'h00, 8'h55);
        #1; chk("ext_init_hi", 32'(req_gnt), 32'd0);
        @(negedge clk); busy = 1'b0; #1;
        chk("ext_init_lo", 32'(req_gnt), 32'd0);
        @(negedge clk); #1;
        chk("ext_gnt", 32'(req_gnt), 32'b0001);
        @(negedge clk); req_valid = 4'b0000; #1;
`ifdef MPQ_SCHED_GUARD_EN
        chk("ext_drop_valid", 32'(cmd_valid), 32'd0);
        chk("ext_drop_err",   32'(err),       32'd1);
        $display("txn: grant id=%0d cmd=%0d dropped", gnt_id, cmd);
        @(negedge clk); #1;
        chk("ext_err_once",   32'(err),       32'd0);
        chk("ext_no_valid",   32'(cmd_valid), 32'd0);
        chk("ext_count",      32'(dut.count_reg), 32'd0);
`else
        chk("ext_fwd_valid", 32'(cmd_valid), 32'd1);
        chk("ext_fwd_cmd",   32'(cmd),       32'd1);
        chk("ext_fwd_value", 32'(value),     32'h55);
        chk("ext_fwd_err",   32'(err),       32'd0);
        $display("txn: grant id=%0d cmd=%0d index=%02h value=%02h", gnt_id, cmd, index, value);
        @(negedge clk); #1;
        chk("ext_one_cycle", 32'(cmd_valid), 32'd0);
        chk("ext_err_zero",  32'(err),       32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
